// File: rtl/if_fetch_stage.sv
// ------------------------------------------------------------------------
// if_fetch_stage : PC, single-outstanding imem read, prefetch queue. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemRdy,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        Stall,
  output logic        InstrValid,
  output logic [31:0] InstrOut,
  output logic [31:0] PCPlus4Out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   tag_q, tag_d;
  logic          out_q, out_d;
  logic          disc_q, disc_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc4_mem   [DEPTH];

  logic          pop;
  logic          resp;
  logic          push;
  logic          accept;
  logic [CW:0]   occ;

  assign InstrValid = (cnt_q != '0);
  assign pop        = InstrValid & ~Stall & ~Branch;
  assign resp       = IMemRValid & out_q;
  assign push       = resp & ~disc_q & ~Branch;

  // Queue slots already committed: held entries plus the in-flight read, less this cycle's pop.
  assign occ     = {1'b0, cnt_q} + {{CW{1'b0}}, out_q} - {{CW{1'b0}}, pop};
  assign IMemReq = Reset & ~Branch & (~out_q | IMemRValid) & (occ < DEPTH_C);
  assign accept  = IMemReq & IMemRdy;

  assign IMemAddr   = pc_q;
  assign InstrOut   = InstrValid ? instr_mem[rd_q] : 32'h0;
  assign PCPlus4Out = InstrValid ? pc4_mem[rd_q]   : 32'h0;

  always_comb begin
    pc_d   = pc_q;
    tag_d  = tag_q;
    out_d  = out_q;
    disc_d = disc_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;

    if (Branch) begin
      pc_d  = BranchTarget & ~32'h3;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (accept) begin
        pc_d  = pc_q + 32'd4;
        tag_d = pc_q;
      end
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    if (accept)    out_d = 1'b1;
    else if (resp) out_d = 1'b0;

    // A read still in flight across a redirect must be swallowed when it lands.
    if (resp)                 disc_d = 1'b0;
    else if (Branch && out_q) disc_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q   <= RESET_PC;
      tag_q  <= RESET_PC;
      out_q  <= 1'b0;
      disc_q <= 1'b0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      tag_q  <= tag_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      instr_mem[wr_q] <= IMemRData;
      pc4_mem[wr_q]   <= tag_q + 32'd4;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ------------------------------------------------------------------------
// tb_if_fetch_stage : vector table, scoreboard and directed corner cases. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_stage;

  localparam int unsigned DEPTH_A = 2;
  localparam logic [31:0] RST_A   = 32'h0000_0000;
  localparam int unsigned DEPTH_B = 4;
  localparam logic [31:0] RST_B   = 32'hFFFF_FFF8;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic        a_req, a_rdy, a_rvalid, a_branch, a_stall, a_valid;
  logic [31:0] a_addr, a_rdata, a_target, a_instr, a_pc4;
  logic        b_req, b_rdy, b_rvalid, b_branch, b_stall, b_valid;
  logic [31:0] b_addr, b_rdata, b_target, b_instr, b_pc4;

  if_fetch_stage #(.RESET_PC(RST_A), .DEPTH(DEPTH_A)) u_a (
    .Clk(Clk), .Reset(Reset), .IMemReq(a_req), .IMemAddr(a_addr), .IMemRdy(a_rdy),
    .IMemRValid(a_rvalid), .IMemRData(a_rdata), .Branch(a_branch), .BranchTarget(a_target),
    .Stall(a_stall), .InstrValid(a_valid), .InstrOut(a_instr), .PCPlus4Out(a_pc4));

  if_fetch_stage #(.RESET_PC(RST_B), .DEPTH(DEPTH_B)) u_b (
    .Clk(Clk), .Reset(Reset), .IMemReq(b_req), .IMemAddr(b_addr), .IMemRdy(b_rdy),
    .IMemRValid(b_rvalid), .IMemRData(b_rdata), .Branch(b_branch), .BranchTarget(b_target),
    .Stall(b_stall), .InstrValid(b_valid), .InstrOut(b_instr), .PCPlus4Out(b_pc4));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  // Scoreboard: every accepted, not-yet-flushed fetch in program order.
  typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } ent_t;
  ent_t        sb[$];
  logic [31:0] exp_pc;
  bit          mem_pend;
  int          mem_dly;
  logic [31:0] mem_addr;
  bit          m_disc;
  int          lat = 1;

  logic        smp_req, smp_valid;
  logic [31:0] smp_addr, smp_instr, smp_pc4;

  task automatic step_a();
    int q_cnt;
    bit exp_valid, exp_req, pop_e, acc, pend0, rv0;
    a_rvalid = mem_pend && (mem_dly == 0);
    a_rdata  = a_rvalid ? 32'h1000_0000 + mem_addr : 32'h0;
    #1;
    smp_req = a_req; smp_addr = a_addr; smp_valid = a_valid;
    smp_instr = a_instr; smp_pc4 = a_pc4;
    q_cnt     = sb.size() - ((mem_pend && !m_disc) ? 1 : 0);
    exp_valid = (q_cnt > 0);
    pop_e     = exp_valid && !a_stall && !a_branch;
    exp_req   = !a_branch && (!mem_pend || a_rvalid) &&
                ((q_cnt + (mem_pend ? 1 : 0) - (pop_e ? 1 : 0)) < int'(DEPTH_A));
    check("sb_valid", 32'(a_valid), 32'(exp_valid));
    check("sb_req", 32'(a_req), 32'(exp_req));
    check("sb_addr", a_addr, exp_pc);
    if (exp_valid) begin
      check("sb_instr", a_instr, sb[0].instr);
      check("sb_pc4", a_pc4, sb[0].pc4);
    end else begin
      check("sb_instr_idle", a_instr, 32'h0);
      check("sb_pc4_idle", a_pc4, 32'h0);
    end
    check("sb_occupancy", 32'(sb.size() <= int'(DEPTH_A)), 32'h1);
    acc = a_req && a_rdy; pend0 = mem_pend; rv0 = a_rvalid;
    @(posedge Clk);
    if (pop_e) void'(sb.pop_front());
    if (a_branch) begin
      sb.delete();
      m_disc = pend0 && !rv0;
      exp_pc = a_target & ~32'h3;
    end else if (rv0) begin
      m_disc = 1'b0;
    end
    if (rv0) mem_pend = 1'b0;
    if (acc) begin
      mem_pend = 1'b1; mem_addr = a_addr; mem_dly = lat - 1;
      sb.push_back('{instr: 32'h1000_0000 + exp_pc, pc4: exp_pc + 32'd4});
      exp_pc = exp_pc + 32'd4;
    end else if (mem_pend && mem_dly > 0) begin
      mem_dly--;
    end
    @(negedge Clk);
  endtask

  task automatic reset_all();
    Reset = 1'b0;
    sb.delete(); exp_pc = RST_A; mem_pend = 1'b0; mem_dly = 0; m_disc = 1'b0;
    a_rvalid = 1'b0; a_rdata = 32'h0; a_branch = 1'b0;
    b_rvalid = 1'b0; b_rdata = 32'h0; b_branch = 1'b0; b_rdy = 1'b0; b_stall = 1'b0;
    #1;
    check("rst_a_req", 32'(a_req), 32'h0);
    check("rst_a_addr", a_addr, RST_A);
    check("rst_a_valid", 32'(a_valid), 32'h0);
    check("rst_a_instr", a_instr, 32'h0);
    check("rst_a_pc4", a_pc4, 32'h0);
    check("rst_b_req", 32'(b_req), 32'h0);
    check("rst_b_addr", b_addr, RST_B);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic b_cyc(input bit rdy, input bit rv, input logic [31:0] rd,
                       input bit br, input logic [31:0] tgt, input bit st);
    b_rdy = rdy; b_rvalid = rv; b_rdata = rd; b_branch = br; b_target = tgt; b_stall = st;
    #1;
  endtask

  typedef struct {
    bit          rst;
    bit          stall;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc4;
  } vec_t;
  vec_t tbl [17];

  initial begin
    bit got;
    // Free-running fetch, then a fresh run with a 5-cycle stall while the head is PC 0.
    tbl[0]  = '{1, 0, 1, 32'h00, 0, 32'h00};
    tbl[1]  = '{0, 0, 1, 32'h04, 0, 32'h00};
    tbl[2]  = '{0, 0, 1, 32'h08, 1, 32'h04};
    tbl[3]  = '{0, 0, 1, 32'h0C, 1, 32'h08};
    tbl[4]  = '{0, 0, 1, 32'h10, 1, 32'h0C};
    tbl[5]  = '{0, 0, 1, 32'h14, 1, 32'h10};
    tbl[6]  = '{1, 0, 1, 32'h00, 0, 32'h00};
    tbl[7]  = '{0, 0, 1, 32'h04, 0, 32'h00};
    tbl[8]  = '{0, 1, 0, 32'h08, 1, 32'h04};
    tbl[9]  = '{0, 1, 0, 32'h08, 1, 32'h04};
    tbl[10] = '{0, 1, 0, 32'h08, 1, 32'h04};
    tbl[11] = '{0, 1, 0, 32'h08, 1, 32'h04};
    tbl[12] = '{0, 1, 0, 32'h08, 1, 32'h04};
    tbl[13] = '{0, 0, 1, 32'h08, 1, 32'h04};
    tbl[14] = '{0, 0, 1, 32'h0C, 1, 32'h08};
    tbl[15] = '{0, 0, 1, 32'h10, 1, 32'h0C};
    tbl[16] = '{0, 0, 1, 32'h14, 1, 32'h10};

    a_rdy = 1'b1; a_rvalid = 1'b0; a_rdata = 32'h0; a_branch = 1'b0; a_target = 32'h0; a_stall = 1'b0;
    b_rdy = 1'b0; b_rvalid = 1'b0; b_rdata = 32'h0; b_branch = 1'b0; b_target = 32'h0; b_stall = 1'b0;
    #2;

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) reset_all();
      a_stall = tbl[i].stall; a_branch = 1'b0; a_rdy = 1'b1; lat = 1;
      step_a();
      check($sformatf("tbl%0d_req", i), 32'(smp_req), 32'(tbl[i].req));
      check($sformatf("tbl%0d_addr", i), smp_addr, tbl[i].addr);
      check($sformatf("tbl%0d_valid", i), 32'(smp_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_pc4", i), smp_pc4, tbl[i].pc4);
      check($sformatf("tbl%0d_instr", i), smp_instr,
            tbl[i].valid ? 32'h1000_0000 + tbl[i].pc4 - 32'd4 : 32'h0);
    end

    // Redirect in the same cycle as a response, with a poppable head.
    a_branch = 1'b1; a_target = 32'h0000_0203; a_stall = 1'b0;
    step_a();
    check("br_cycle_req", 32'(smp_req), 32'h0);
    check("br_cycle_head", 32'(smp_valid), 32'h1);
    a_branch = 1'b0;
    step_a();
    check("br_flush_valid", 32'(smp_valid), 32'h0);
    check("br_next_req", 32'(smp_req), 32'h1);
    check("br_next_addr", smp_addr, 32'h0000_0200);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step_a();
      if (smp_valid) begin
        got = 1'b1;
        check("br_first_pc4", smp_pc4, 32'h0000_0204);
      end
    end
    check("br_delivered", 32'(got), 32'h1);

    for (int k = 0; k < 150; k++) begin
      a_stall  = ($urandom_range(0, 2) == 0);
      a_rdy    = ($urandom_range(0, 3) != 0);
      a_branch = ($urandom_range(0, 15) == 0);
      a_target = $urandom;
      lat      = $urandom_range(1, 3);
      step_a();
    end

    // Reset while a read is in flight and an entry is queued.
    a_branch = 1'b0; a_rdy = 1'b1;
    reset_all();
    a_stall = 1'b1; lat = 3;
    repeat (4) step_a();
    reset_all();
    a_stall = 1'b0; lat = 1;
    step_a();
    check("rst_mid_req", 32'(smp_req), 32'h1);
    check("rst_mid_addr", smp_addr, RST_A);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step_a();
      if (smp_valid) begin
        got = 1'b1;
        check("rst_mid_pc4", smp_pc4, 32'h4);
        check("rst_mid_instr", smp_instr, 32'h1000_0000);
      end
    end
    check("rst_mid_delivered", 32'(got), 32'h1);

    // PC wrap with IMemRdy toggling 1,0,1 on the DEPTH=4 instance.
    reset_all();
    b_cyc(1, 0, 32'h0, 0, 32'h0, 1);
    check("wrap_addr0", b_addr, 32'hFFFF_FFF8);
    check("wrap_req0", 32'(b_req), 32'h1);
    @(negedge Clk);
    b_cyc(0, 1, 32'hA000_0000, 0, 32'h0, 1);
    check("wrap_addr1", b_addr, 32'hFFFF_FFFC);
    @(negedge Clk);
    b_cyc(1, 0, 32'h0, 0, 32'h0, 1);
    check("wrap_hold_addr", b_addr, 32'hFFFF_FFFC);
    check("wrap_hold_req", 32'(b_req), 32'h1);
    check("wrap_head_pc4", b_pc4, 32'hFFFF_FFFC);
    @(negedge Clk);
    b_cyc(1, 1, 32'hA000_0001, 0, 32'h0, 1);
    check("wrap_addr2", b_addr, 32'h0000_0000);
    @(negedge Clk);
    b_cyc(0, 1, 32'hA000_0002, 0, 32'h0, 0);
    check("wrap_e0_pc4", b_pc4, 32'hFFFF_FFFC);
    check("wrap_e0_instr", b_instr, 32'hA000_0000);
    @(negedge Clk);
    b_cyc(0, 0, 32'h0, 0, 32'h0, 0);
    check("wrap_e1_pc4", b_pc4, 32'h0000_0000);
    check("wrap_e1_instr", b_instr, 32'hA000_0001);
    @(negedge Clk);
    check("wrap_e2_pc4", b_pc4, 32'h0000_0004);
    check("wrap_e2_instr", b_instr, 32'hA000_0002);

    // Redirect with two queued entries and the 0x10 read outstanding.
    reset_all();
    b_cyc(1, 0, 32'h0, 1, 32'h0000_0008, 1);
    check("flush_br0_req", 32'(b_req), 32'h0);
    @(negedge Clk);
    b_cyc(1, 0, 32'h0, 0, 32'h0, 1);
    check("flush_addr8", b_addr, 32'h0000_0008);
    @(negedge Clk);
    b_cyc(1, 1, 32'hB000_0008, 0, 32'h0, 1);
    check("flush_addrC", b_addr, 32'h0000_000C);
    @(negedge Clk);
    b_cyc(1, 1, 32'hB000_000C, 0, 32'h0, 1);
    check("flush_addr10", b_addr, 32'h0000_0010);
    @(negedge Clk);
    b_cyc(1, 0, 32'h0, 1, 32'h0000_0103, 1);
    check("flush_br_req", 32'(b_req), 32'h0);
    check("flush_br_head_pc4", b_pc4, 32'h0000_000C);
    @(negedge Clk);
    b_cyc(1, 1, 32'hDEAD_BEEF, 0, 32'h0, 0);
    check("flush_valid0", 32'(b_valid), 32'h0);
    check("flush_new_addr", b_addr, 32'h0000_0100);
    check("flush_new_req", 32'(b_req), 32'h1);
    @(negedge Clk);
    b_cyc(0, 1, 32'hB000_0100, 0, 32'h0, 0);
    check("flush_dropped", 32'(b_valid), 32'h0);
    @(negedge Clk);
    b_cyc(0, 0, 32'h0, 0, 32'h0, 0);
    check("flush_first_valid", 32'(b_valid), 32'h1);
    check("flush_first_pc4", b_pc4, 32'h0000_0104);
    check("flush_first_instr", b_instr, 32'hB000_0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
